// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sequential divider.
package arith_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

    // Width of an iteration counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring division iteration on {P,Q}.
module nr_div_step #(
    parameter int N = 32
) (
    input  logic [N:0]   i_p,     // signed partial remainder
    input  logic [N-1:0] i_q,     // quotient bits developed so far / remaining dividend bits
    input  logic [N:0]   i_dmag,  // divisor magnitude
    output logic [N:0]   o_p,
    output logic [N-1:0] o_q
);

    logic [N:0] w_shift;

    // Shift {P,Q} left by one. P stays within [-D, D), so 2P+bit fits in
    // N+1 bits and dropping the old sign bit loses nothing.
    assign w_shift = {i_p[N-1:0], i_q[N-1]};

    // Subtract while the remainder is non-negative, otherwise add back.
    assign o_p = i_p[N] ? (w_shift + i_dmag) : (w_shift - i_dmag);

    // The new quotient bit is 1 when the new remainder is non-negative.
    assign o_q = {i_q[N-2:0], ~o_p[N]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: truncating quotient and dividend-signed
// remainder, one quotient bit per clock via non-restoring iteration.
module seq_divider
    import arith_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    div_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic [N:0]    r_p;        // signed partial remainder
    logic [N-1:0]  r_q;        // |dividend| on entry, quotient magnitude on exit
    logic [N:0]    r_dmag;     // |divisor|
    logic          r_q_neg;    // operand signs differ
    logic          r_r_neg;    // dividend negative
    logic          r_dz_cap;   // captured divisor was zero

    logic          r_busy;
    logic          r_done;
    logic [N-1:0]  r_quot;
    logic [N-1:0]  r_rem;
    logic          r_dz;

    logic [N-1:0]  w_dvd_mag;
    logic [N:0]    w_dvs_mag;
    logic          w_dvs_zero;
    logic [N:0]    w_p_next;
    logic [N-1:0]  w_q_next;
    logic [N-1:0]  w_rem_mag;
    logic [N-1:0]  w_quot;
    logic [N-1:0]  w_rem;

    // Operand magnitudes; -2^(N-1) maps to 2^(N-1), which is still exact
    // when read as an unsigned N-bit value.
    assign w_dvd_mag  = dividend[N-1] ? -dividend : dividend;
    assign w_dvs_mag  = {1'b0, (divisor[N-1] ? -divisor : divisor)};
    assign w_dvs_zero = (divisor == '0);

    nr_div_step #(.N(N)) u_step (
        .i_p    (r_p),
        .i_q    (r_q),
        .i_dmag (r_dmag),
        .o_p    (w_p_next),
        .o_q    (w_q_next)
    );

    // Final correction: a negative partial remainder gets the divisor added
    // back. The corrected value lies in [0, D), so N bits suffice. On a
    // divide by zero no iteration ran and r_q still holds |dividend|, which
    // is exactly the remainder magnitude to report.
    assign w_rem_mag = r_dz_cap ? r_q
                     : (r_p[N] ? (r_p[N-1:0] + r_dmag[N-1:0]) : r_p[N-1:0]);
    assign w_quot    = r_dz_cap ? '1 : (r_q_neg ? -r_q : r_q);
    assign w_rem     = r_r_neg ? -w_rem_mag : w_rem_mag;

    // Control FSM and datapath registers.
    // NOTE: every register here is assigned with <= so that all state
    // updates in a cycle see the pre-edge values; mixing in = would make the
    // result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_dmag   <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz_cap <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p      <= '0;
                        r_q      <= w_dvd_mag;
                        r_dmag   <= w_dvs_mag;
                        r_q_neg  <= dividend[N-1] ^ divisor[N-1];
                        r_r_neg  <= dividend[N-1];
                        r_dz_cap <= w_dvs_zero;
                        r_cnt    <= CW'(N);
                        r_busy   <= 1'b1;
                        r_dz     <= 1'b0;
                        r_state  <= w_dvs_zero ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_p   <= w_p_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quot  <= w_quot;
                    r_rem   <= w_rem;
                    r_dz    <= r_dz_cap;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a scoreboard of expected results
// computed with plain signed arithmetic, checked on every cycle, plus
// hand-computed literal expectations for the directed cases.
module tb_seq_divider;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           acc;   // cycle index at which start was sampled
        int           due;   // cycle index in which done must be seen
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] last_q = '0;
    logic [N-1:0] last_r = '0;
    logic         last_dz = 1'b0;
    logic         cmp_active;
    logic         cmp_due;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating signed division from the language operators.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc);
        exp_t   e;
        longint la;
        longint lb;
        e.acc = acc;
        e.a   = a;
        e.b   = b;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.due = acc + 2;
        end else begin
            la    = longint'(signed'(a));
            lb    = longint'(signed'(b));
            e.q   = N'(la / lb);
            e.r   = N'(la % lb);
            e.dz  = 1'b0;
            e.due = acc + N + 2;
        end
        return e;
    endfunction

    // Per-cycle comparison of every output against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            cmp_active = (sb.size() > 0) && (cyc > sb[0].acc) && (cyc <= sb[0].due);
            cmp_due    = (sb.size() > 0) && (cyc == sb[0].due);
            if (cmp_due) begin
                last_q  = sb[0].q;
                last_r  = sb[0].r;
                last_dz = sb[0].dz;
                if (!sb[0].dz) begin
                    check("identity q*d+r",
                          N'(longint'(signed'(quotient)) * longint'(signed'(sb[0].b))
                             + longint'(signed'(remainder))),
                          sb[0].a);
                end
                void'(sb.pop_front());
            end
            check("done", done, cmp_due);
            check("busy", busy, cmp_active);
            check("quotient", quotient, last_q);
            check("remainder", remainder, last_r);
            check("div_by_zero", div_by_zero, (cmp_active && !cmp_due) ? 1'b0 : last_dz);
        end
    end

    // Drive one start at the current negedge and record its expectation.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, cyc));
    endtask

    // Complete operation; returns at the first negedge where a new start
    // would be accepted.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        int c;
        int d;
        c = cyc;
        d = (b == '0) ? 2 : N + 2;
        issue(a, b);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + d + 1) @(negedge clk);
    endtask

    task automatic check_result(input string name, input logic [N-1:0] q,
                                input logic [N-1:0] r, input logic dz);
        check({name, " quotient"}, quotient, q);
        check({name, " remainder"}, remainder, r);
        check({name, " div_by_zero"}, div_by_zero, dz);
    endtask

    logic [N-1:0] corners [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h2,
                                  32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};

    initial begin
        int c;
        int nb;
        int dl;
        int seen;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        check("reset div_by_zero", div_by_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with latency and busy-width measurement.
        c  = cyc;
        nb = 0;
        dl = -1;
        issue(32'd100, 32'd7);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (busy) nb++;
            if (done && dl < 0) dl = cyc - c;
        end
        check("100/7 done latency", dl, 34);
        check("100/7 busy cycles", nb, 34);
        check_result("100/7", 32'd14, 32'd2, 1'b0);

        // Sign matrix.
        run_op(-32'sd100, 32'd7);
        check_result("-100/7", -32'sd14, -32'sd2, 1'b0);
        run_op(32'd100, -32'sd7);
        check_result("100/-7", -32'sd14, 32'd2, 1'b0);
        run_op(-32'sd100, -32'sd7);
        check_result("-100/-7", 32'd14, -32'sd2, 1'b0);

        // Divide by zero, then a normal operation clears the flag.
        run_op(32'd5, 32'd0);
        check_result("5/0", 32'hFFFF_FFFF, 32'd5, 1'b1);
        run_op(32'd6, 32'd3);
        check_result("6/3", 32'd2, 32'd0, 1'b0);

        // Most-negative dividend.
        run_op(32'h8000_0000, 32'hFFFF_FFFF);
        check_result("min/-1", 32'h8000_0000, 32'd0, 1'b0);
        run_op(32'h8000_0000, 32'd1);
        check_result("min/1", 32'h8000_0000, 32'd0, 1'b0);

        // Starts while busy are ignored.
        c = cyc;
        issue(32'd1000, 32'd10);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 5) @(negedge clk);
        dividend = 32'd7;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 20) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + N + 3) @(negedge clk);
        check_result("1000/10 with repulses", 32'd100, 32'd0, 1'b0);

        // start held high through DONE: accepted only on the following IDLE cycle.
        c = cyc;
        issue(-32'sd77, 32'd5);
        @(negedge clk);
        dividend = 32'd999;
        divisor  = -32'sd10;
        sb.push_back(model(32'd999, -32'sd10, c + N + 3));
        while (cyc < c + N + 4) @(negedge clk);
        start = 1'b0;
        while (cyc < c + 2 * N + 6) @(negedge clk);
        check_result("999/-10 after held start", -32'sd99, 32'd9, 1'b0);

        // Asynchronous reset mid-operation.
        c = cyc;
        issue(32'd12345, 32'd67);
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_q  = '0;
        last_r  = '0;
        last_dz = 1'b0;
        #1;
        check("mid-op reset busy", busy, 1'b0);
        check("mid-op reset done", done, 1'b0);
        check("mid-op reset quotient", quotient, '0);
        check("mid-op reset remainder", remainder, '0);
        check("mid-op reset div_by_zero", div_by_zero, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no done after reset", seen, 0);
        run_op(32'd12345, 32'd67);
        check_result("12345/67 after reset", 32'd184, 32'd17, 1'b0);

        // Corner operand cross product.
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7; j++) begin
                run_op(corners[i], corners[j]);
            end
        end

        // Random operands, biased toward small and corner divisors.
        for (int k = 0; k < 800; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = N'($urandom_range(0, 16)) - 32'd8;
                1:       rb = corners[$urandom_range(0, 6)];
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = corners[$urandom_range(0, 6)];
            run_op(ra, rb);
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
